// File: rtl/request_queue.sv
// Request FIFO with registered ready/valid status and a hold register that
// keeps the last popped word visible on out_data while the queue is empty.
module request_queue #(
  parameter int                 WIDTH   = 32,
  parameter int                 DEPTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = 32'h1C00_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             push, pop;

  // Status depends only on registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;
  assign out_data  = out_valid ? mem_q[rdPtr_q] : hold_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    hold_d  = hold_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
        hold_d  = mem_q[rdPtr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      hold_q  <= RST_VAL;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // Storage is left unreset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

endmodule

// File: doc/request_queue.md
REQUEST_QUEUE -- requirements
Module: request_queue

Interface
REQ-001 SHALL: parameter WIDTH, default 32, width of one request word.
REQ-002 SHALL: parameter DEPTH, default 4, number of entries; legal values are powers of two, 2..64.
REQ-003 SHALL: parameter RST_VAL, default 32'h1C00_0000 (WIDTH bits), value presented on out_data after reset.
REQ-004 SHALL: clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL: flush  input  1  discard all queued entries.
REQ-007 SHALL: in_valid  input  1  producer offers in_data.
REQ-008 SHALL: in_ready  output  1  queue can accept a word this cycle.
REQ-009 SHALL: in_data  input  WIDTH  request word.
REQ-010 SHALL: out_valid  output  1  out_data is a queued entry.
REQ-011 SHALL: out_ready  input  1  consumer takes out_data this cycle.
REQ-012 SHALL: out_data  output  WIDTH  head entry, or held value when empty.
REQ-013 SHALL: count  output  $clog2(DEPTH+1)  number of queued entries.

Function
REQ-014 SHALL: push occurs when in_valid && in_ready, writing in_data at the tail on that edge.
REQ-015 SHALL: pop occurs when out_valid && out_ready, advancing the head on that edge.
REQ-016 SHALL: in_ready = (count < DEPTH), combinational from registered state only, no dependency on out_ready.
REQ-017 SHALL: out_valid = (count != 0), registered-state only, no dependency on in_valid.
REQ-018 SHALL: latency in->out is one cycle minimum; no combinational bypass from in_data to out_data.
REQ-019 SHALL: simultaneous push and pop leave count unchanged; both pointers advance.
REQ-020 SHALL: count increments on push-only, decrements on pop-only, never exceeds DEPTH or underflows.
REQ-021 SHALL: read/write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-022 SHALL: a hold register latches the popped word on every pop.
REQ-023 SHALL: out_data = entry at head when count != 0, else hold register.
REQ-024 SHALL: when full, in_valid is ignored (in_ready=0) even if a pop occurs the same cycle; the slot frees next cycle.
REQ-025 SHALL: flush clears count and both pointers on the next edge; push and pop in the flush cycle are suppressed; hold register is unchanged.
REQ-026 SHALL: rst has priority over flush; flush has priority over push/pop.
REQ-027 SHALL: entry storage contents need no reset; only pointers, count and hold register are reset.

Reset
REQ-028 SHALL: after rst, count=0, pointers=0, in_ready=1, out_valid=0, out_data=RST_VAL.
REQ-029 SHALL: rst asserted mid-operation (any count) produces the REQ-028 state on the next edge regardless of in_valid, out_ready or flush.

Verification
REQ-030 SHALL: rst 1 cycle, then idle -> out_data=32'h1C00_0000, out_valid=0, in_ready=1, count=0.
REQ-031 SHALL: push A0..A3 (DEPTH=4) with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; then pop 4 -> A0..A3 in order, out_data holds A3 after empty.
REQ-032 SHALL: steady push+pop every cycle for 3*DEPTH cycles -> count stays 1, data order preserved across pointer wrap.
REQ-033 SHALL: full queue, in_valid=1 and out_ready=1 same cycle -> only pop occurs, count 4->3; push accepted next cycle.
REQ-034 SHALL: count=3, flush=1 with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, out_data = prior hold value.
REQ-035 SHALL: rst and flush together with count=2 -> next cycle out_data=RST_VAL, count=0.
